// File: rtl/miriscv_mdu_ctrl_if.sv
// Bus between the issue/writeback/MDU side and the MDU execute-stage sequencer.
interface miriscv_mdu_ctrl_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MDU_OP_W = 3
);
    // Issue side
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [MDU_OP_W-1:0] issue_op_i;
    logic [XLEN-1:0]     issue_a_i;
    logic [XLEN-1:0]     issue_b_i;
    logic                flush_i;

    // Writeback side
    logic                wb_valid_o;
    logic                wb_ready_i;
    logic [XLEN-1:0]     wb_result_o;

    // MDU side
    logic                mdu_req_o;
    logic [MDU_OP_W-1:0] mdu_op_o;
    logic [XLEN-1:0]     mdu_port_a_o;
    logic [XLEN-1:0]     mdu_port_b_o;
    logic                mdu_kill_o;
    logic                mdu_keep_o;
    logic [XLEN-1:0]     mdu_result_i;
    logic                mdu_stall_req_i;

    // Sequencer view
    modport slave (
        input  issue_valid_i, issue_op_i, issue_a_i, issue_b_i, flush_i,
        input  wb_ready_i, mdu_result_i, mdu_stall_req_i,
        output issue_ready_o, wb_valid_o, wb_result_o,
        output mdu_req_o, mdu_op_o, mdu_port_a_o, mdu_port_b_o, mdu_kill_o, mdu_keep_o
    );

    // Environment view (issue logic, writeback and MDU)
    modport master (
        output issue_valid_i, issue_op_i, issue_a_i, issue_b_i, flush_i,
        output wb_ready_i, mdu_result_i, mdu_stall_req_i,
        input  issue_ready_o, wb_valid_o, wb_result_o,
        input  mdu_req_o, mdu_op_o, mdu_port_a_o, mdu_port_b_o, mdu_kill_o, mdu_keep_o
    );
endinterface

// File: rtl/miriscv_mdu_ctrl.sv
// Execute-stage MDU sequencer: latches one op, drives the MDU until it stops
// stalling, registers the result for writeback and short-circuits repeats
// through a one-entry last-result cache.
module miriscv_mdu_ctrl #(
    parameter bit          CACHE_EN = 1'b1,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MDU_OP_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    miriscv_mdu_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic                req;
    logic                kill;
    logic                keep;
    logic                wb_valid;
    logic [MDU_OP_W-1:0] op;
    logic [XLEN-1:0]     port_a;
    logic [XLEN-1:0]     port_b;
    logic [XLEN-1:0]     wb_result;

    logic                cache_valid;
    logic [MDU_OP_W-1:0] cache_op;
    logic [XLEN-1:0]     cache_a;
    logic [XLEN-1:0]     cache_b;
    logic [XLEN-1:0]     cache_data;

    logic                issue_ready_c;
    logic                accept_c;
    logic                hit_c;
    logic                complete_c;

    // Handshake decode; ready depends on the current-cycle ready/flush inputs
    always_comb begin
        issue_ready_c = !rst_i && !bus.flush_i &&
                        ((state == IDLE) || ((state == DONE) && bus.wb_ready_i));
        accept_c      = bus.issue_valid_i && issue_ready_c;
        hit_c         = CACHE_EN && cache_valid &&
                        (bus.issue_op_i == cache_op) &&
                        (bus.issue_a_i == cache_a) &&
                        (bus.issue_b_i == cache_b);
        complete_c    = (state == BUSY) && req && !bus.mdu_stall_req_i;
    end

    // Sequencer state, MDU drive registers, result register and cache
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            req         <= 1'b0;
            kill        <= 1'b0;
            keep        <= 1'b0;
            wb_valid    <= 1'b0;
            op          <= '0;
            port_a      <= '0;
            port_b      <= '0;
            wb_result   <= '0;
            cache_valid <= 1'b0;
            cache_op    <= '0;
            cache_a     <= '0;
            cache_b     <= '0;
            cache_data  <= '0;
        end else begin
            kill <= 1'b0;
            if (bus.flush_i) begin
                // Flush wins: abandon everything; only a running MDU op needs a kill
                kill     <= (state == BUSY);
                state    <= IDLE;
                req      <= 1'b0;
                keep     <= 1'b0;
                wb_valid <= 1'b0;
            end else begin
                case (state)
                    BUSY: begin
                        if (complete_c) begin
                            state     <= DONE;
                            req       <= 1'b0;
                            keep      <= 1'b1;
                            wb_valid  <= 1'b1;
                            wb_result <= bus.mdu_result_i;
                            if (CACHE_EN) begin
                                cache_valid <= 1'b1;
                                cache_op    <= op;
                                cache_a     <= port_a;
                                cache_b     <= port_b;
                                cache_data  <= bus.mdu_result_i;
                            end
                        end
                    end
                    DONE: begin
                        if (bus.wb_ready_i && !accept_c) begin
                            state    <= IDLE;
                            keep     <= 1'b0;
                            wb_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase

                // Accept is only possible from IDLE or a consumed DONE
                if (accept_c) begin
                    op     <= bus.issue_op_i;
                    port_a <= bus.issue_a_i;
                    port_b <= bus.issue_b_i;
                    if (hit_c) begin
                        state     <= DONE;
                        req       <= 1'b0;
                        keep      <= 1'b1;
                        wb_valid  <= 1'b1;
                        wb_result <= cache_data;
                    end else begin
                        state    <= BUSY;
                        req      <= 1'b1;
                        keep     <= 1'b0;
                        wb_valid <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.issue_ready_o = issue_ready_c;
    assign bus.wb_valid_o    = wb_valid;
    assign bus.wb_result_o   = wb_result;
    assign bus.mdu_req_o     = req;
    assign bus.mdu_op_o      = op;
    assign bus.mdu_port_a_o  = port_a;
    assign bus.mdu_port_b_o  = port_b;
    assign bus.mdu_kill_o    = kill;
    assign bus.mdu_keep_o    = keep;

endmodule

// File: tb/tb_miriscv_mdu_ctrl.sv
// Directed bench for miriscv_mdu_ctrl: a cached and an uncached instance
// share one stimulus stream, each with its own behavioural MDU.
module tb_miriscv_mdu_ctrl;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned MDU_OP_W = 3;

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV   = 3'd4;
    localparam logic [2:0] OP_DIVU  = 3'd5;
    localparam logic [2:0] OP_REM   = 3'd6;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   stall_cfg;
    int   cnt_c;
    int   cnt_n;

    miriscv_mdu_ctrl_if #(.XLEN(XLEN), .MDU_OP_W(MDU_OP_W)) bus ();
    miriscv_mdu_ctrl_if #(.XLEN(XLEN), .MDU_OP_W(MDU_OP_W)) bus_nc ();

    miriscv_mdu_ctrl #(.CACHE_EN(1'b1), .XLEN(XLEN), .MDU_OP_W(MDU_OP_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    miriscv_mdu_ctrl #(.CACHE_EN(1'b0), .XLEN(XLEN), .MDU_OP_W(MDU_OP_W)) dut_nc (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_nc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural MDU arithmetic
    function automatic logic [31:0] mdu_model(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (op)
            OP_MUL:   return p[31:0];
            OP_MULHU: return p[63:32];
            OP_DIV:   return (b == 32'd0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
            OP_DIVU:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:   return (b == 32'd0) ? a : 32'($signed(a) % $signed(b));
            default:  return 32'd0;
        endcase
    endfunction

    // MDU stall model: stall for stall_cfg cycles of each request
    always @(posedge clk) begin
        cnt_c <= bus.mdu_req_o ? cnt_c + 1 : 0;
        cnt_n <= bus_nc.mdu_req_o ? cnt_n + 1 : 0;
    end

    assign bus.mdu_result_i       = mdu_model(bus.mdu_op_o, bus.mdu_port_a_o, bus.mdu_port_b_o);
    assign bus.mdu_stall_req_i    = bus.mdu_req_o && (cnt_c < stall_cfg);
    assign bus_nc.mdu_result_i    = mdu_model(bus_nc.mdu_op_o, bus_nc.mdu_port_a_o, bus_nc.mdu_port_b_o);
    assign bus_nc.mdu_stall_req_i = bus_nc.mdu_req_o && (cnt_n < stall_cfg);

    assign bus_nc.issue_valid_i = bus.issue_valid_i;
    assign bus_nc.issue_op_i    = bus.issue_op_i;
    assign bus_nc.issue_a_i     = bus.issue_a_i;
    assign bus_nc.issue_b_i     = bus.issue_b_i;
    assign bus_nc.flush_i       = bus.flush_i;
    assign bus_nc.wb_ready_i    = bus.wb_ready_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.issue_valid_i = 1'b1;
        bus.issue_op_i    = op;
        bus.issue_a_i     = a;
        bus.issue_b_i     = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        stall_cfg   = 0;
        rst         = 1'b1;
        bus.issue_valid_i = 1'b0;
        bus.issue_op_i    = '0;
        bus.issue_a_i     = '0;
        bus.issue_b_i     = '0;
        bus.flush_i       = 1'b0;
        bus.wb_ready_i    = 1'b0;

        // Reset state
        offer(OP_MUL, 32'd1, 32'd1);
        tick();
        tick();
        chk("rst_ready", 128'(bus.issue_ready_o), 128'd0);
        chk("rst_flags", 128'({bus.wb_valid_o, bus.mdu_req_o, bus.mdu_kill_o, bus.mdu_keep_o}), 128'd0);
        chk("rst_data", {bus.wb_result_o, 29'd0, bus.mdu_op_o, bus.mdu_port_a_o, bus.mdu_port_b_o}, 128'd0);
        bus.issue_valid_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_release_ready", 128'(bus.issue_ready_o), 128'd1);

        // MUL 7 * -3, zero stall
        offer(OP_MUL, 32'd7, 32'hFFFF_FFFD);
        #1;
        chk("mul_ready", 128'(bus.issue_ready_o), 128'd1);
        tick();
        bus.issue_valid_i = 1'b0;
        chk("mul_n1", 128'({bus.mdu_req_o, bus.wb_valid_o, bus.mdu_port_b_o}), {94'd0, 2'b10, 32'hFFFF_FFFD});
        tick();
        chk("mul_n2", 128'({bus.wb_valid_o, bus.mdu_keep_o, bus.mdu_req_o, bus.wb_result_o}), {93'd0, 3'b110, 32'hFFFF_FFEB});
        bus.wb_ready_i = 1'b1;
        tick();
        bus.wb_ready_i = 1'b0;
        chk("mul_consumed", 128'({bus.wb_valid_o, bus.mdu_keep_o}), 128'd0);

        // DIVU 100 / 0 with a 33-cycle stall
        stall_cfg = 33;
        offer(OP_DIVU, 32'd100, 32'd0);
        tick();
        bus.issue_valid_i = 1'b0;
        bus.issue_a_i     = 32'h5555_5555;
        bus.issue_b_i     = 32'hAAAA_AAAA;
        for (int i = 0; i < 33; i++) begin
            chk($sformatf("divu_hold_%0d", i),
                128'({bus.mdu_req_o, bus.wb_valid_o, bus.mdu_op_o, bus.mdu_port_a_o, bus.mdu_port_b_o}),
                {59'd0, 2'b10, OP_DIVU, 32'd100, 32'd0});
            tick();
        end
        chk("divu_last_req", 128'({bus.mdu_req_o, bus.mdu_stall_req_i, bus.wb_valid_o}), 128'b100);
        tick();
        chk("divu_result", 128'({bus.wb_valid_o, bus.wb_result_o}), {95'd0, 1'b1, 32'hFFFF_FFFF});
        bus.wb_ready_i = 1'b1;
        tick();
        bus.wb_ready_i = 1'b0;

        // REM 17 % 5 twice back-to-back: cached instance hits, uncached re-requests
        stall_cfg = 0;
        offer(OP_REM, 32'd17, 32'd5);
        tick();
        chk("rem1_req", 128'({bus.mdu_req_o, bus_nc.mdu_req_o}), 128'b11);
        tick();
        chk("rem1_result", 128'({bus.wb_valid_o, bus.wb_result_o}), {95'd0, 1'b1, 32'd2});
        bus.wb_ready_i = 1'b1;
        #1;
        chk("rem2_ready", 128'(bus.issue_ready_o), 128'd1);
        tick();
        bus.issue_valid_i = 1'b0;
        chk("rem2_hit", 128'({bus.wb_valid_o, bus.mdu_req_o, bus.mdu_keep_o, bus.wb_result_o}), {93'd0, 3'b101, 32'd2});
        chk("rem2_nc_req", 128'({bus_nc.mdu_req_o, bus_nc.wb_valid_o}), 128'b10);
        tick();
        chk("rem2_hit_consumed", 128'({bus.wb_valid_o, bus.mdu_req_o}), 128'd0);
        chk("rem2_nc_result", 128'({bus_nc.wb_valid_o, bus_nc.wb_result_o}), {95'd0, 1'b1, 32'd2});
        tick();
        bus.wb_ready_i = 1'b0;
        chk("rem2_nc_idle", 128'(bus_nc.wb_valid_o), 128'd0);

        // DIV 1000 / 7 flushed mid-stall, then re-issued
        stall_cfg = 20;
        offer(OP_DIV, 32'd1000, 32'd7);
        tick();
        bus.issue_valid_i = 1'b0;
        chk("div_req", 128'(bus.mdu_req_o), 128'd1);
        for (int i = 0; i < 4; i++) tick();
        bus.flush_i = 1'b1;
        #1;
        chk("flush_blocks_ready", 128'(bus.issue_ready_o), 128'd0);
        tick();
        bus.flush_i = 1'b0;
        chk("flush_kill", 128'({bus.mdu_kill_o, bus.mdu_keep_o, bus.mdu_req_o, bus.wb_valid_o}), 128'b1000);
        tick();
        chk("flush_kill_once", 128'({bus.mdu_kill_o, bus.wb_valid_o}), 128'd0);
        tick();
        chk("flush_no_valid", 128'({bus.wb_valid_o, bus.mdu_req_o}), 128'd0);
        stall_cfg = 2;
        offer(OP_DIV, 32'd1000, 32'd7);
        tick();
        bus.issue_valid_i = 1'b0;
        chk("div2_miss_req", 128'({bus.mdu_req_o, bus.wb_valid_o}), 128'b10);
        tick();
        tick();
        chk("div2_wait", 128'(bus.wb_valid_o), 128'd0);
        tick();
        chk("div2_result", 128'({bus.wb_valid_o, bus.wb_result_o}), {95'd0, 1'b1, 32'd142});
        bus.wb_ready_i = 1'b1;
        tick();
        bus.wb_ready_i = 1'b0;

        // MULHU with writeback back-pressure, then same-cycle accept of MUL
        stall_cfg = 0;
        offer(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        bus.issue_valid_i = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mulhu_hold_%0d", i),
                128'({bus.wb_valid_o, bus.mdu_keep_o, bus.mdu_kill_o, bus.mdu_req_o, bus.wb_result_o}),
                {92'd0, 4'b1100, 32'hFFFF_FFFE});
            tick();
        end
        offer(OP_MUL, 32'd6, 32'd7);
        bus.wb_ready_i = 1'b1;
        #1;
        chk("mul2_ready", 128'(bus.issue_ready_o), 128'd1);
        tick();
        bus.issue_valid_i = 1'b0;
        bus.wb_ready_i    = 1'b0;
        chk("mul2_busy", 128'({bus.mdu_req_o, bus.wb_valid_o, bus.mdu_keep_o, bus.mdu_port_a_o}), {93'd0, 3'b100, 32'd6});
        tick();
        chk("mul2_result", 128'({bus.wb_valid_o, bus.wb_result_o}), {95'd0, 1'b1, 32'd42});
        bus.wb_ready_i = 1'b1;
        tick();
        bus.wb_ready_i = 1'b0;

        // Flush in IDLE only blocks accept
        offer(OP_MUL, 32'd6, 32'd7);
        bus.flush_i = 1'b1;
        #1;
        chk("idle_flush_ready", 128'(bus.issue_ready_o), 128'd0);
        tick();
        bus.flush_i = 1'b0;
        bus.issue_valid_i = 1'b0;
        chk("idle_flush_noop", 128'({bus.mdu_req_o, bus.wb_valid_o, bus.mdu_kill_o}), 128'd0);

        // Reset in the middle of a BUSY DIVU clears state and the cache
        stall_cfg = 10;
        offer(OP_DIVU, 32'd9, 32'd2);
        tick();
        bus.issue_valid_i = 1'b0;
        tick();
        chk("pre_rst_busy", 128'(bus.mdu_req_o), 128'd1);
        rst = 1'b1;
        tick();
        chk("midrst_flags", 128'({bus.wb_valid_o, bus.mdu_req_o, bus.mdu_kill_o, bus.mdu_keep_o, bus.issue_ready_o}), 128'd0);
        chk("midrst_data", {bus.wb_result_o, 29'd0, bus.mdu_op_o, bus.mdu_port_a_o, bus.mdu_port_b_o}, 128'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 128'(bus.issue_ready_o), 128'd1);
        stall_cfg = 0;
        offer(OP_MUL, 32'd6, 32'd7);
        tick();
        bus.issue_valid_i = 1'b0;
        chk("post_rst_cache_miss", 128'({bus.mdu_req_o, bus.wb_valid_o}), 128'b10);
        tick();
        chk("post_rst_result", 128'({bus.wb_valid_o, bus.wb_result_o}), {95'd0, 1'b1, 32'd42});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
